alu_cmp_issue_stage: RTL
========================

// Module: alu_cmp_issue_stage
// PURPOSE
//  Handshaked issue stage directly upstream of the 32-bit unsigned compare unit (y = a>b ? 1 : 0).
//  Buffers operand pairs, drives the comparator's a/b combinationally from the buffer head, then
//  registers the 32-bit result with its tag for a valid/ready consumer.
//  This decouples the combinational comparator from producer/consumer stalls.
// PARAMETERS
//  DATA_W  32  operand/result width; must equal comparator width
//  TAG_W   4   sideband tag carried unchanged from input to output
//  DEPTH   2   operand buffer entries; power of two, >=2
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operand pair offered
//  in_ready   out  1        stage can accept (buffer not full)
//  in_a       in   DATA_W   operand a
//  in_b       in   DATA_W   operand b
//  in_tag     in   TAG_W    request tag
//  cmp_a      out  DATA_W   to comparator a (buffer head, 0 when empty)
//  cmp_b      out  DATA_W   to comparator b (buffer head, 0 when empty)
//  cmp_y      in   DATA_W   comparator result (combinational from cmp_a/cmp_b)
//  out_valid  out  1        registered result valid
//  out_ready  in   1        consumer accepts
//  out_y      out  DATA_W   registered result
//  out_tag    out  TAG_W    tag of out_y
// BEHAVIOUR
//  - Reset (async, rst=1): buffer count=0, pointers=0, out_valid=0, out_y=0, out_tag=0, in_ready=1.
//  - Push: in_valid&in_ready at edge writes {a,b,tag} to tail. in_ready = (count!=DEPTH), registered-state only, no out_ready path.
//  - Issue: fire = (count!=0) & (!out_valid | out_ready). On fire: out_y<=cmp_y, out_tag<=head tag, out_valid<=1, pop head.
//  - Drain: out_valid&out_ready without fire -> out_valid<=0; out_y/out_tag hold last value.
//  - Latency: accept at edge N -> out_valid high after edge N+1 (2 cycles valid-to-valid). Throughput 1/cycle with out_ready=1.
//  - Simultaneous push+pop: count unchanged; at count=DEPTH no push occurs (in_ready=0) even if popping.
//  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - out_valid held, out_ready=0: out_y/out_tag stable until accepted (no overwrite).
//  - Order strictly FIFO; tags never reordered or dropped.
//  - Reset mid-operation discards all buffered and registered entries; out_valid drops asynchronously.
//  - cmp_y sampled only on fire; all 32 bits registered (upper bits expected 0 from comparator, not forced).
// CONFIGURATION
//  ALU_CMP_ISSUE_STATS_EN defined: adds ports stat_issued out 32 (count of fire events) and
//   stat_stall out 32 (cycles with out_valid&!out_ready); both reset to 0, wrap 0xFFFFFFFF->0.
//  Undefined: ports and counters absent; datapath behaviour identical.
// STRUCTURE
//  - Shared package alu_pkg: DATA_W=32 constant, tag_t typedef, struct opnd_t {a,b,tag}.
//  - Sub-module alu_cmp_issue_fifo: DEPTH-entry circular buffer of opnd_t (push/pop/count/head).
//  - Top: fire logic, output register, optional stats counters; comparator instantiated outside.
// TESTING (bench instantiates comparator on cmp_a/cmp_b/cmp_y)
//  - Reset: rst pulse mid-cycle -> out_valid=0, in_ready=1, out_y=0 immediately.
//  - Single op a=5,b=3,tag=1, out_ready=1 -> out_valid 2 cycles later, out_y=1, out_tag=1; a=3,b=5 -> 0.
//  - Equal/extremes: a=b=0xFFFFFFFF -> 0; a=0x80000000,b=0x7FFFFFFF -> 1 (unsigned).
//  - Backpressure: out_ready=0, push 3 ops -> in_ready=0 after 2 buffered +1 in out reg; release -> tags 0,1,2 in order.
//  - Streaming: 16 back-to-back ops, out_ready=1 -> 16 results on consecutive cycles, in_ready never low.
//  - STATS_EN: 4 issues, 3 stall cycles -> stat_issued=4, stat_stall=3; preload-free wrap check via force at 0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU compare issue slice: operand/result width, tag type and the
// buffered operand record.
package alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 4;

   typedef logic [TAG_W-1:0] tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      tag_t              tag;
   } opnd_t;

endpackage

// File: rtl/alu_cmp_issue_stage_if.sv
// Producer, comparator and consumer signals of the compare issue stage.
// slave is the stage's view, master the surrounding environment's.
interface alu_cmp_issue_stage_if
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = alu_pkg::DATA_W,
   parameter int unsigned TAG_W  = alu_pkg::TAG_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [TAG_W-1:0]  in_tag;
   logic [DATA_W-1:0] cmp_a;
   logic [DATA_W-1:0] cmp_b;
   logic [DATA_W-1:0] cmp_y;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_y;
   logic [TAG_W-1:0]  out_tag;

   modport slave (
      input  in_valid, in_a, in_b, in_tag, cmp_y, out_ready,
      output in_ready, cmp_a, cmp_b, out_valid, out_y, out_tag
   );

   modport master (
      output in_valid, in_a, in_b, in_tag, cmp_y, out_ready,
      input  in_ready, cmp_a, cmp_b, out_valid, out_y, out_tag
   );

endinterface

// File: rtl/alu_cmp_issue_fifo.sv
// DEPTH-entry circular operand buffer (DEPTH a power of two, >= 2). Push/pop requests are
// qualified internally against full/empty.
module alu_cmp_issue_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  opnd_t                    wr_data,
   output opnd_t                    head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   opnd_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // With DEPTH a power of two, count==DEPTH exactly when its MSB is set.
   assign full    = count[PTR_W];
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/alu_cmp_issue_stage.sv
// Issue stage in front of an external 32-bit unsigned comparator: buffers operands, presents
// the head to the comparator, registers result+tag. Optional ALU_CMP_ISSUE_STATS_EN adds counters.
module alu_cmp_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = alu_pkg::DATA_W,
   parameter int unsigned TAG_W  = alu_pkg::TAG_W,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   alu_cmp_issue_stage_if.slave       bus
`ifdef ALU_CMP_ISSUE_STATS_EN
   ,
   output logic [31:0]                stat_issued,
   output logic [31:0]                stat_stall
`endif
);

   opnd_t                  wr_data;
   opnd_t                  head;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   fire;
   logic                   out_valid_q;
   logic [DATA_W-1:0]      out_y_q;
   logic [TAG_W-1:0]       out_tag_q;

   always_comb begin
      wr_data     = '0;
      wr_data.a   = bus.in_a;
      wr_data.b   = bus.in_b;
      wr_data.tag = bus.in_tag;
   end

   // in_ready depends on buffer state only, never on out_ready.
   assign bus.in_ready = ~full;
   assign push         = bus.in_valid & ~full;
   assign fire         = ~empty & (~out_valid_q | bus.out_ready);

   assign bus.cmp_a = empty ? '0 : head.a;
   assign bus.cmp_b = empty ? '0 : head.b;

   alu_cmp_issue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (fire),
      .wr_data (wr_data),
      .head    (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_tag_q   <= '0;
      end else if (fire) begin
         out_valid_q <= 1'b1;
         out_y_q     <= bus.cmp_y;
         out_tag_q   <= head.tag;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = out_y_q;
   assign bus.out_tag   = out_tag_q;

`ifdef ALU_CMP_ISSUE_STATS_EN
   logic [31:0] issued_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (fire)                         issued_cnt <= issued_cnt + 1'b1;
         if (out_valid_q && !bus.out_ready) stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign stat_issued = issued_cnt;
   assign stat_stall  = stall_cnt;
`endif

endmodule
